// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } ctrlState_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle: the pipeline (master) reports stage info, the controller (slave) returns stalls, flushes and forwarding selects.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
) ();
  import pipe_ctrl_pkg::*;

  logic [REG_W-1:0] rs1D, rs2D, rs1E, rs2E;
  logic [REG_W-1:0] rdE, rdM, rdW;
  logic             RegWEnE, RegWEnM, RegWEnW;
  logic             WBSelE, PCSelE, MemReqM, MemRdyM;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             MemTimeout;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
    output RegWEnE, RegWEnM, RegWEnW, WBSelE, PCSelE, MemReqM, MemRdyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, MemTimeout, StallCnt, FlushCnt
  );

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
    input  RegWEnE, RegWEnM, RegWEnW, WBSelE, PCSelE, MemReqM, MemRdyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, MemTimeout, StallCnt, FlushCnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX-stage operand forwarding select for one source operand; M beats W.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rsE,
  input  logic [REG_W-1:0] rdM,
  input  logic [REG_W-1:0] rdW,
  input  logic             regWEnM,
  input  logic             regWEnW,
  output logic [1:0]       fwdSel
);

  always_comb begin
    fwdSel = FWD_RF;
    if (regWEnM && (rdM != '0) && (rdM == rsE)) begin
      fwdSel = FWD_M;
    end else if (regWEnW && (rdW != '0) && (rdW == rsE)) begin
      fwdSel = FWD_W;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: priming,
// memory wait states with timeout, branch/load-use handling, forwarding and perf counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = 4,
  parameter int unsigned MAX_WAIT    = 16,
  parameter int unsigned CNT_W       = 32
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int unsigned INIT_W = $clog2(INIT_CYCLES + 1);
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  ctrlState_t       state;
  logic [INIT_W-1:0] initCnt;
  logic [WAIT_W-1:0] waitCnt;
  logic              memTimeout;
  logic [CNT_W-1:0]  stallCnt, flushCnt;

  logic memWait, loadUse;
  logic stallF, stallD, stallE, stallM, flushD, flushE, flushW;

  assign memWait = hz.MemReqM && !hz.MemRdyM;
  assign loadUse = hz.WBSelE && hz.RegWEnE && (hz.rdE != '0) &&
                   ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));

  // Stage control decode; reset forces bubbles into every stage.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushW = 1'b0;
    if (reset) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushW = 1'b1;
    end else begin
      unique case (state)
        INIT: begin
          stallF = 1'b1;
          flushD = 1'b1;
          flushE = 1'b1;
          flushW = 1'b1;
        end
        RUN: begin
          if (memWait) begin
            {stallF, stallD, stallE, stallM, flushW} = 5'b11111;
          end else if (hz.PCSelE) begin
            flushD = 1'b1;
            flushE = 1'b1;
          end else if (loadUse) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!hz.MemRdyM) begin
            {stallF, stallD, stallE, stallM, flushW} = 5'b11111;
          end
        end
        ERROR: begin
          {stallF, stallD, stallE, stallM, flushW} = 5'b11111;
        end
        default: ;
      endcase
    end
  end

  // Sequencing state, wait/priming counters, sticky error and saturating perf counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= INIT;
      initCnt    <= '0;
      waitCnt    <= '0;
      memTimeout <= 1'b0;
      stallCnt   <= '0;
      flushCnt   <= '0;
    end else begin
      if (stallF && (stallCnt != '1)) begin
        stallCnt <= stallCnt + CNT_W'(1);
      end
      if (flushE && (state != INIT) && (flushCnt != '1)) begin
        flushCnt <= flushCnt + CNT_W'(1);
      end
      unique case (state)
        INIT: begin
          if (initCnt >= INIT_W'(INIT_CYCLES - 1)) begin
            state   <= RUN;
            initCnt <= '0;
          end else begin
            initCnt <= initCnt + INIT_W'(1);
          end
        end
        RUN: begin
          if (memWait) begin
            state   <= MEM_WAIT;
            waitCnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (hz.MemRdyM) begin
            state   <= RUN;
            waitCnt <= '0;
          end else begin
            waitCnt <= waitCnt + WAIT_W'(1);
            if (waitCnt >= WAIT_W'(MAX_WAIT - 1)) begin
              state      <= ERROR;
              memTimeout <= 1'b1;
            end
          end
        end
        ERROR: begin
          memTimeout <= 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

  fwd_unit u_fwdA (
    .rsE     (hz.rs1E),
    .rdM     (hz.rdM),
    .rdW     (hz.rdW),
    .regWEnM (hz.RegWEnM),
    .regWEnW (hz.RegWEnW),
    .fwdSel  (hz.ForwardAE)
  );

  fwd_unit u_fwdB (
    .rsE     (hz.rs2E),
    .rdM     (hz.rdM),
    .rdW     (hz.rdW),
    .regWEnM (hz.RegWEnM),
    .regWEnW (hz.RegWEnW),
    .fwdSel  (hz.ForwardBE)
  );

  assign hz.StallF     = stallF;
  assign hz.StallD     = stallD;
  assign hz.StallE     = stallE;
  assign hz.StallM     = stallM;
  assign hz.FlushD     = flushD;
  assign hz.FlushE     = flushE;
  assign hz.FlushW     = flushW;
  assign hz.MemTimeout = memTimeout;
  assign hz.StallCnt   = stallCnt;
  assign hz.FlushCnt   = flushCnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked each cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned INIT_CYCLES = 4;
  localparam int unsigned MAX_WAIT    = 16;

  logic clk;
  logic reset;
  int   nTests = 0;
  int   nFail  = 0;

  pipe_hazard_ctrl_if #(.CNT_W(32)) hz ();

  pipe_hazard_ctrl #(
    .INIT_CYCLES (INIT_CYCLES),
    .MAX_WAIT    (MAX_WAIT),
    .CNT_W       (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model state: cycles of priming left, whether a memory wait is open and how long, whether dead.
  int          initLeft = INIT_CYCLES;
  bit          waiting = 0;
  int          waitCycles = 0;
  bit          dead = 0;
  int unsigned mStall = 0;
  int unsigned mFlush = 0;

  function automatic logic [1:0] refFwd(input logic [4:0] rs);
    if (hz.RegWEnM && hz.rdM != 0 && hz.rdM == rs) return 2'b10;
    if (hz.RegWEnW && hz.rdW != 0 && hz.rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Per-cycle compare: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}.
  always @(negedge clk) begin
    logic [6:0] expCtl;
    logic [6:0] actCtl;
    bit wait_, lu;
    actCtl = {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushW};
    wait_  = hz.MemReqM && !hz.MemRdyM;
    lu     = hz.WBSelE && hz.RegWEnE && hz.rdE != 0 && (hz.rdE == hz.rs1D || hz.rdE == hz.rs2D);
    if (reset) begin
      initLeft = INIT_CYCLES; waiting = 0; waitCycles = 0; dead = 0; mStall = 0; mFlush = 0;
      expCtl = 7'b0000111;
    end else if (dead)          expCtl = 7'b1111001;
    else if (initLeft > 0)      expCtl = 7'b1000111;
    else if (waiting)           expCtl = hz.MemRdyM ? 7'b0000000 : 7'b1111001;
    else if (wait_)             expCtl = 7'b1111001;
    else if (hz.PCSelE)         expCtl = 7'b0000110;
    else if (lu)                expCtl = 7'b1100010;
    else                        expCtl = 7'b0000000;

    chk("ctl", 32'(actCtl), 32'(expCtl));
    chk("fwdA", 32'(hz.ForwardAE), 32'(refFwd(hz.rs1E)));
    chk("fwdB", 32'(hz.ForwardBE), 32'(refFwd(hz.rs2E)));
    chk("timeout", 32'(hz.MemTimeout), 32'(dead));
    chk("stallCnt", hz.StallCnt, mStall);
    chk("flushCnt", hz.FlushCnt, mFlush);

    if (!reset) begin
      if (expCtl[6] && mStall != 32'hFFFF_FFFF) mStall++;
      if (expCtl[1] && initLeft == 0 && mFlush != 32'hFFFF_FFFF) mFlush++;
      if (dead) ;
      else if (initLeft > 0) initLeft--;
      else if (waiting) begin
        if (hz.MemRdyM) begin
          waiting = 0; waitCycles = 0;
        end else begin
          waitCycles++;
          if (waitCycles >= MAX_WAIT) dead = 1;
        end
      end else if (wait_) begin
        waiting = 1; waitCycles = 1;
      end
    end
  end

  task automatic nextc();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    hz.rs1D = '0; hz.rs2D = '0; hz.rs1E = '0; hz.rs2E = '0;
    hz.rdE = '0; hz.rdM = '0; hz.rdW = '0;
    hz.RegWEnE = 0; hz.RegWEnM = 0; hz.RegWEnW = 0;
    hz.WBSelE = 0; hz.PCSelE = 0; hz.MemReqM = 0; hz.MemRdyM = 0;
  endtask

  task automatic randIn();
    hz.rs1D = 5'($urandom_range(0, 3)); hz.rs2D = 5'($urandom_range(0, 3));
    hz.rs1E = 5'($urandom_range(0, 3)); hz.rs2E = 5'($urandom_range(0, 3));
    hz.rdE = 5'($urandom_range(0, 3)); hz.rdM = 5'($urandom_range(0, 3));
    hz.rdW = 5'($urandom_range(0, 3));
    hz.RegWEnE = 1'($urandom_range(0, 1)); hz.RegWEnM = 1'($urandom_range(0, 1));
    hz.RegWEnW = 1'($urandom_range(0, 1)); hz.WBSelE = 1'($urandom_range(0, 1));
    hz.PCSelE  = ($urandom_range(0, 99) < 15);
    hz.MemReqM = ($urandom_range(0, 99) < 30);
    hz.MemRdyM = ($urandom_range(0, 99) < 60);
  endtask

  initial begin
    reset = 1'b1;
    clearIn();
    @(negedge clk);
    chk("rst_stallF", 32'(hz.StallF), 32'd0);
    chk("rst_flushD", 32'(hz.FlushD), 32'd1);
    chk("rst_stallCnt", hz.StallCnt, 32'd0);
    nextc();
    reset = 1'b0;

    // Priming: exactly INIT_CYCLES cycles of StallF + flushes.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("init_stallF", 32'(hz.StallF), 32'd1);
      chk("init_flushW", 32'(hz.FlushW), 32'd1);
      nextc();
    end
    @(negedge clk);
    chk("run_ctl", 32'({hz.StallF, hz.FlushD, hz.FlushE, hz.FlushW}), 32'd0);
    chk("init_stallCnt", hz.StallCnt, 32'd4);

    // Load-use on x5, then forwarded from M.
    nextc();
    hz.WBSelE = 1; hz.RegWEnE = 1; hz.rdE = 5'd5; hz.rs1D = 5'd5;
    @(negedge clk);
    chk("lu_ctl", 32'({hz.StallF, hz.StallD, hz.FlushE}), 32'b111);
    nextc();
    clearIn();
    hz.RegWEnM = 1; hz.rdM = 5'd5; hz.rs1E = 5'd5;
    @(negedge clk);
    chk("lu_fwdA", 32'(hz.ForwardAE), 32'b10);
    chk("lu_flushCnt", hz.FlushCnt, 32'd1);

    // Forwarding priority on operand B.
    nextc();
    clearIn();
    hz.RegWEnM = 1; hz.RegWEnW = 1; hz.rdM = 5'd7; hz.rdW = 5'd7; hz.rs2E = 5'd7;
    @(negedge clk);
    chk("fwdB_M", 32'(hz.ForwardBE), 32'b10);
    nextc();
    hz.rdM = 5'd0;
    @(negedge clk);
    chk("fwdB_W", 32'(hz.ForwardBE), 32'b01);
    nextc();
    hz.rdW = 5'd0; hz.rs2E = 5'd0;
    @(negedge clk);
    chk("fwdB_RF", 32'(hz.ForwardBE), 32'b00);

    // Branch beats load-use.
    nextc();
    clearIn();
    hz.PCSelE = 1; hz.WBSelE = 1; hz.RegWEnE = 1; hz.rdE = 5'd3; hz.rs2D = 5'd3;
    @(negedge clk);
    chk("br_ctl", 32'({hz.FlushD, hz.FlushE, hz.StallF, hz.StallD}), 32'b1100);

    // Three wait cycles then completion.
    nextc();
    clearIn();
    hz.MemReqM = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mw_stall", 32'({hz.StallF, hz.StallM, hz.FlushW}), 32'b111);
      nextc();
    end
    hz.MemRdyM = 1;
    @(negedge clk);
    chk("mw_done", 32'({hz.StallF, hz.StallM, hz.FlushW}), 32'b000);
    nextc();
    hz.MemReqM = 0; hz.MemRdyM = 0;
    @(negedge clk);
    chk("mw_run", 32'({hz.StallF, hz.FlushW}), 32'b00);

    // Timeout after MAX_WAIT wait cycles; sticky.
    nextc();
    hz.MemReqM = 1; hz.MemRdyM = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("to_pending", 32'(hz.MemTimeout), 32'd0);
      nextc();
    end
    hz.MemReqM = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("to_sticky", 32'({hz.MemTimeout, hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW}), 32'b111111);
      nextc();
    end
    reset = 1'b1;
    @(negedge clk);
    chk("to_cleared", 32'(hz.MemTimeout), 32'd0);
    nextc();
    reset = 1'b0;

    // Randomized traffic with occasional mid-operation resets.
    for (int i = 0; i < 3000; i++) begin
      nextc();
      randIn();
      reset = ($urandom_range(0, 299) == 0);
    end
    nextc();
    reset = 1'b0;
    clearIn();
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage RV32I pipeline (F/D/E/M/W).
- Generates stall and flush enables for the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers, plus EX-stage operand forwarding selects.
- Sequences post-reset pipeline priming and data-memory wait states, with a timeout error.
- Maintains saturating stall/flush performance counters.

Parameters:
- INIT_CYCLES, 4: cycles after reset release during which all stages are flushed.
- MAX_WAIT, 16: maximum consecutive data-memory wait cycles before error.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- rs1D, rs2D  in  5 each  D-stage source registers
- rs1E, rs2E  in  5 each  E-stage source registers
- rdE, rdM, rdW  in  5 each  destination register per stage
- RegWEnE, RegWEnM, RegWEnW  in  1 each  register write enable per stage
- WBSelE  in  1  1 = E-stage instruction is a load (writeback from memory)
- PCSelE  in  1  branch/jump taken, resolved in E
- MemReqM  in  1  M-stage instruction accesses data memory
- MemRdyM  in  1  data memory completes the access this cycle
- StallF, StallD, StallE, StallM  out  1 each  hold the stage register
- FlushD, FlushE, FlushW  out  1 each  load a bubble (all control zero) into the stage register
- ForwardAE, ForwardBE  out  2 each  00 regfile, 01 from W, 10 from M
- MemTimeout  out  1  sticky error flag
- StallCnt, FlushCnt  out  CNT_W each  performance counters

Behaviour:
- FSM states: INIT, RUN, MEM_WAIT, ERROR.
- Reset: state=INIT, init counter=0, wait counter=0, MemTimeout=0, StallCnt=0, FlushCnt=0.
- All outputs are combinational from state and inputs. While reset is high, StallF..StallM=0 and FlushD/E/W=1.
- INIT:
  - StallF=1, FlushD=FlushE=FlushW=1.
  - After INIT_CYCLES cycles in INIT, go to RUN.
  - No other events are honoured in INIT.
- RUN, evaluated in priority order:
  - Memory wait (MemReqM && !MemRdyM): StallF/D/E/M=1, FlushW=1, no flushes of D/E. Next state MEM_WAIT, wait counter=1.
  - Branch (PCSelE): FlushD=1, FlushE=1, no stalls. A load-use hazard in the same cycle is ignored, because the dependent instruction is squashed.
  - Load-use (WBSelE && RegWEnE && rdE!=0 && (rdE==rs1D || rdE==rs2D)): StallF=1, StallD=1, FlushE=1 for exactly one cycle. On the next cycle the load is in M and forwarding resolves the dependency.
  - Otherwise: all stall/flush outputs are 0.
- MEM_WAIT:
  - Same outputs as the RUN memory-wait case.
  - Wait counter increments each cycle.
  - On MemRdyM=1: outputs for that cycle are no stall and FlushW=0, so the access retires. Next state RUN, wait counter cleared.
  - A PCSelE held in E during the wait is deferred and acted on in the first RUN cycle.
  - If the wait counter reaches MAX_WAIT with MemRdyM still 0: go to ERROR and set MemTimeout=1.
- ERROR:
  - StallF/D/E/M=1, FlushW=1 permanently.
  - MemTimeout is sticky until reset.
- Forwarding (combinational, all states), per operand:
  - ForwardAE=10 if RegWEnM && rdM!=0 && rdM==rs1E.
  - Else ForwardAE=01 if RegWEnW && rdW!=0 && rdW==rs1E.
  - Else ForwardAE=00.
  - ForwardBE uses the same rules with rs2E.
  - M has priority over W.
- Counters:
  - StallCnt +1 every cycle in which StallF=1, INIT included.
  - FlushCnt +1 every cycle in which FlushE=1 outside INIT.
  - Both saturate at all-ones and never wrap.
- Reset mid-operation: immediate return to INIT from any state; counters and flags cleared asynchronously.

Decomposition:
- Package pipe_ctrl_pkg: state enum (INIT, RUN, MEM_WAIT, ERROR); forwarding encodings FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10; register index width constant 5.
- One sub-module, fwd_unit: purely combinational forwarding select, instantiated once per operand.

Test Plan:
- Reset release with INIT_CYCLES=4: Flush D/E/W=1 and StallF=1 for exactly 4 cycles, then all 0; StallCnt=4.
- Load x5 in E, D reads rs1=5: one cycle of StallF=StallD=FlushE=1. Next cycle, with rdM=5 and rs1E=5, ForwardAE=10; FlushCnt increments by 1.
- rdM=rdW=7, both writing, rs2E=7: ForwardBE=10. Same case with rdM=0: ForwardBE=01. rs2E=0 with rdM=rdW=0: ForwardBE=00.
- PCSelE=1 together with a load-use match: FlushD=FlushE=1 and StallF=StallD=0.
- MemReqM=1 with MemRdyM low for 3 cycles: stalls and FlushW held for 3 cycles; the 4th cycle (MemRdyM=1) has no stall; state returns to RUN.
- MemRdyM held low with MAX_WAIT=16: MemTimeout rises after 16 wait cycles and stays high with all stalls asserted until reset.
